// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder plus registered carry, LSB-first operand shift.
// Optional build macro SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             last;

  full_adder u_fa (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  // result bit enters at the MSB; the full word is complete on the last step
  assign r_next = {fa_s, r_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= r_next[WIDTH-1:1];
        carry <= fa_co;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= r_next;
          cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the carry register during the final step
          ovf  <= carry ^ fa_co;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 main instance, WIDTH=2 sweep instance).
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  // Launch one add from IDLE and wait (bounded) for done; returns edges from accept to done.
  task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output logic [7:0] os, output logic oc, output int lat);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    os = sum; oc = cout;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({cout, sum} !== 9'h000) begin bad++; $display("FAIL reset_sum got=%h exp=000", {cout, sum}); end
`ifdef SERIAL_ADDER_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_timing();
    int first_done;
    int done_cnt;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timing_busy got=%b exp=1", busy); end
    first_done = -1; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) begin
        total++;
        if (sum !== 8'h00) begin bad++; $display("FAIL timing_hold k=%0d got=%h exp=00", k, sum); end
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        total++;
        if ({cout, sum} !== 9'h010) begin bad++; $display("FAIL timing_sum got=%h exp=010", {cout, sum}); end
      end
    end
    total++; if (first_done !== 8) begin bad++; $display("FAIL timing_latency got=%0d exp=8", first_done); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL timing_done_count got=%0d exp=1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timing_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0] s; logic c; int lat;
    logic [8:0] ta [3] = '{9'h0FF, 9'h0FF, 9'h080};
    logic [8:0] tb [3] = '{9'h001, 9'h0FF, 9'h080};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] ex [3] = '{9'h100, 9'h1FF, 9'h100};
    for (int i = 0; i < 3; i++) begin
      do_add(ta[i][7:0], tb[i][7:0], tc[i], s, c, lat);
      total++;
      if ({c, s} !== ex[i] || lat !== 8)
        begin bad++; $display("FAIL directed_%0d got=%h lat=%0d exp=%h lat=8", i, {c, s}, lat, ex[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, s; logic rc, c; int lat; logic [8:0] ex;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      ex = 9'(ra) + 9'(rb) + 9'(rc);
      do_add(ra, rb, rc, s, c, lat);
      total++;
      if ({c, s} !== ex || lat !== 8)
        begin bad++; $display("FAIL random %h+%h+%b got=%h lat=%0d exp=%h", ra, rb, rc, {c, s}, lat, ex); end
    end
  endtask

  task automatic test_width2_sweep();
    int n;
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i >> 3); b2 = 2'(i >> 1); cin2 = i[0];
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 10) begin @(posedge clk); #1; n++; end
      total++;
      if ({cout2, sum2} !== 3'((i >> 3) + ((i >> 1) & 3) + (i & 1)) || n !== 2)
        begin bad++; $display("FAIL w2_sweep case=%0d got=%h n=%0d exp=%h n=2", i, {cout2, sum2}, n,
                              3'((i >> 3) + ((i >> 1) & 3) + (i & 1))); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt, first_done;
    logic [8:0] got;
    a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; first_done = -1; got = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        got = {cout, sum};
        if (first_done < 0) first_done = k;
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    total++; if (first_done !== 8) begin bad++; $display("FAIL ignore_latency got=%0d exp=8", first_done); end
    total++; if (got !== 9'h08E) begin bad++; $display("FAIL ignore_sum got=%h exp=08E", got); end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    a = 8'hC3; b = 8'h4D; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    done_cnt = 0;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk); #1;
      total++;
      if (done !== ((k % 10) == 8)) begin bad++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, (k % 10) == 8); end
      if (done) begin
        done_cnt++;
        total++;
        if ({cout, sum} !== 9'h111) begin bad++; $display("FAIL b2b_sum got=%h exp=111", {cout, sum}); end
      end
      if (k == 28) start = 1'b0;
    end
    total++; if (done_cnt !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", done_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [7:0] s; logic c; int lat; int pulses;
    do_add(8'hA5, 8'h3C, 1'b1, s, c, lat);
    a = 8'h77; b = 8'h66; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if ({cout, sum} !== 9'h000) begin bad++; $display("FAIL abort_sum got=%h exp=000", {cout, sum}); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (done) pulses++; end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; if (done) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    do_add(8'h12, 8'h34, 1'b0, s, c, lat);
    total++; if ({c, s} !== 9'h046) begin bad++; $display("FAIL abort_next_add got=%h exp=046", {c, s}); end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] s, ra, rb; logic c, rc; int lat; logic exp_ovf; logic [7:0] es;
    do_add(8'h7F, 8'h01, 1'b0, s, c, lat);
    total++; if (ovf !== 1'b1 || s !== 8'h80) begin bad++; $display("FAIL ovf_pos got=%b/%h exp=1/80", ovf, s); end
    do_add(8'hFF, 8'h01, 1'b0, s, c, lat);
    total++; if (ovf !== 1'b0 || c !== 1'b1) begin bad++; $display("FAIL ovf_neg got=%b/%b exp=0/1", ovf, c); end
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      es = ra + rb + 8'(rc);
      exp_ovf = (ra[7] == rb[7]) && (es[7] != ra[7]);
      do_add(ra, rb, rc, s, c, lat);
      total++;
      if (ovf !== exp_ovf) begin bad++; $display("FAIL ovf_rand %h+%h+%b got=%b exp=%b", ra, rb, rc, ovf, exp_ovf); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_directed();
    test_random();
    test_width2_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
